vmul_wbqueue: RTL and testbench

- Writeback queue directly downstream of the vector multiply unit's stage 3.
- Captures each completed multiply result with its destination register, write-enable and lane mask, and buffers up to DEPTH results.
- Presents the oldest result to the vector register-file write arbiter.
- Back-pressures the multiply pipeline when full and reports pending writes to a queried register for hazard interlock.

---
 rtl/vmul_wbqueue.sv | 111 +++++++++++
 tb/tb_vmul_wbqueue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmul_wbqueue.sv
// Writeback queue between vector multiply stage 3 and the register-file write arbiter.
// Latency: an entry enqueued at edge N is presented on wb_* in the following cycle. There is no in_* -> wb_* bypass.
// Backpressure: stall is raised from the registered count when the queue is full. Upstream holds in_* until stall drops.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   in_valid/in_result/in_dst/       completed multiply result from stage 3
//   in_dst_we/in_dst_mask
//   flush                            squash every queued entry
//   wb_grant                         arbiter accepts the head entry
//   wb_we/wb_dst/wb_mask/wb_data     head entry presented to the arbiter
//   stall                            queue full
//   chk_reg/chk_hit                  pending-write lookup for hazard interlock
module vmul_wbqueue #(
   parameter int LOG2WIDTH    = 5,
   parameter int LOG2NUMLANES = 4,
   parameter int REGIDWIDTH   = 4,
   parameter int LOG2DEPTH    = 2,
   parameter int WIDTH        = 2**LOG2WIDTH,
   parameter int NUMLANES     = 2**LOG2NUMLANES,
   parameter int DEPTH        = 2**LOG2DEPTH
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      in_valid,
   input  logic [NUMLANES*WIDTH-1:0] in_result,
   input  logic [REGIDWIDTH-1:0]     in_dst,
   input  logic                      in_dst_we,
   input  logic [NUMLANES-1:0]       in_dst_mask,
   input  logic                      flush,
   input  logic                      wb_grant,
   output logic                      wb_we,
   output logic [REGIDWIDTH-1:0]     wb_dst,
   output logic [NUMLANES-1:0]       wb_mask,
   output logic [NUMLANES*WIDTH-1:0] wb_data,
   output logic                      stall,
   input  logic [REGIDWIDTH-1:0]     chk_reg,
   output logic                      chk_hit
);

   typedef struct packed {
      logic [REGIDWIDTH-1:0]     dst;
      logic [NUMLANES-1:0]       mask;
      logic [NUMLANES*WIDTH-1:0] data;
   } ent_t;

   ent_t                 mem [DEPTH];
   logic [LOG2DEPTH-1:0] head;
   logic [LOG2DEPTH-1:0] tail;
   logic [LOG2DEPTH:0]   count;

   logic in_req;
   logic enq;
   logic deq;

   // A result with no write-enable or no active lane carries no write. It is consumed without taking a slot.
   assign in_req = in_valid & in_dst_we & (|in_dst_mask);

   // stall comes only from registered state. A dequeue at full therefore frees the slot one cycle later.
   assign stall  = (count == (LOG2DEPTH+1)'(DEPTH));
   assign wb_we  = (count != '0);
   assign enq    = in_req & ~stall & ~flush;
   assign deq    = wb_we & wb_grant & ~flush;

   assign wb_dst  = mem[head].dst;
   assign wb_mask = mem[head].mask;
   assign wb_data = mem[head].data;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + LOG2DEPTH'(1);
         if (deq) head <= head + LOG2DEPTH'(1);
         case ({enq, deq})
            2'b10:   count <= count + (LOG2DEPTH+1)'(1);
            2'b01:   count <= count - (LOG2DEPTH+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage is not reset. Its contents are only observed while wb_we is high.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail] <= '{dst: in_dst, mask: in_dst_mask, data: in_result};
      end
   end

   // Slot i is live when its distance from head, modulo DEPTH, is below count.
   // The incoming request also counts as pending, so the interlock sees a write one cycle before it lands.
   // A same-cycle flush is ignored here. That only errs on the side of stalling.
   always_comb begin
      logic [LOG2DEPTH-1:0] slot_off;
      slot_off = '0;
      chk_hit  = in_req & (in_dst == chk_reg);
      for (int i = 0; i < DEPTH; i++) begin
         slot_off = LOG2DEPTH'(i) - head;
         if (((LOG2DEPTH+1)'(slot_off) < count) && (mem[i].dst == chk_reg)) begin
            chk_hit = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vmul_wbqueue.sv
module tb_vmul_wbqueue;
   localparam int LOG2WIDTH    = 5;
   localparam int LOG2NUMLANES = 4;
   localparam int REGIDWIDTH   = 4;
   localparam int LOG2DEPTH    = 2;
   localparam int WIDTH        = 2**LOG2WIDTH;
   localparam int NUMLANES     = 2**LOG2NUMLANES;
   localparam int DEPTH        = 2**LOG2DEPTH;
   localparam int DW           = NUMLANES*WIDTH;

   logic                  clk = 1'b0;
   logic                  resetn = 1'b0;
   logic                  in_valid = 1'b0;
   logic [DW-1:0]         in_result = '0;
   logic [REGIDWIDTH-1:0] in_dst = '0;
   logic                  in_dst_we = 1'b0;
   logic [NUMLANES-1:0]   in_dst_mask = '0;
   logic                  flush = 1'b0;
   logic                  wb_grant = 1'b0;
   logic                  wb_we;
   logic [REGIDWIDTH-1:0] wb_dst;
   logic [NUMLANES-1:0]   wb_mask;
   logic [DW-1:0]         wb_data;
   logic                  stall;
   logic [REGIDWIDTH-1:0] chk_reg = '0;
   logic                  chk_hit;

   vmul_wbqueue #(
      .LOG2WIDTH(LOG2WIDTH), .LOG2NUMLANES(LOG2NUMLANES),
      .REGIDWIDTH(REGIDWIDTH), .LOG2DEPTH(LOG2DEPTH)
   ) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_result(in_result),
      .in_dst(in_dst), .in_dst_we(in_dst_we), .in_dst_mask(in_dst_mask),
      .flush(flush), .wb_grant(wb_grant), .wb_we(wb_we), .wb_dst(wb_dst),
      .wb_mask(wb_mask), .wb_data(wb_data), .stall(stall),
      .chk_reg(chk_reg), .chk_hit(chk_hit)
   );

   always #5 clk = ~clk;

   // Reference model: the queue contents as a plain list, oldest first.
   typedef struct {
      logic [REGIDWIDTH-1:0] dst;
      logic [NUMLANES-1:0]   mask;
      logic [DW-1:0]         data;
   } ent_t;
   ent_t q[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rdata();
      logic [DW-1:0] d;
      for (int l = 0; l < NUMLANES; l++) d[l*WIDTH +: WIDTH] = $urandom();
      return d;
   endfunction

   task automatic drv(bit v, int d, bit we, logic [NUMLANES-1:0] m, logic [DW-1:0] dat,
                      bit g, bit f, int c);
      in_valid    = v;
      in_dst      = REGIDWIDTH'(d);
      in_dst_we   = we;
      in_dst_mask = m;
      in_result   = dat;
      wb_grant    = g;
      flush       = f;
      chk_reg     = REGIDWIDTH'(c);
   endtask

   task automatic idle(bit g);
      drv(0, 0, 0, '0, '0, g, 0, 0);
   endtask

   // Compare every output against the model.
   task automatic cmp_model();
      logic hit;
      hit = in_valid && in_dst_we && (in_dst_mask != 0) && (in_dst == chk_reg);
      foreach (q[i]) if (q[i].dst == chk_reg) hit = 1'b1;
      chk("stall", DW'(stall), DW'(q.size() == DEPTH));
      chk("wb_we", DW'(wb_we), DW'(q.size() != 0));
      chk("chk_hit", DW'(chk_hit), DW'(hit));
      if (q.size() != 0) begin
         chk("wb_dst", DW'(wb_dst), DW'(q[0].dst));
         chk("wb_mask", DW'(wb_mask), DW'(q[0].mask));
         chk("wb_data", wb_data, q[0].data);
      end
   endtask

   // Apply one clock edge to the model.
   task automatic model_edge();
      bit   full;
      bit   enq;
      ent_t e;
      full = (q.size() == DEPTH);
      if (flush) begin
         q.delete();
      end else begin
         enq = in_valid && in_dst_we && (in_dst_mask != 0) && !full;
         if (q.size() != 0 && wb_grant) void'(q.pop_front());
         if (enq) begin
            e.dst  = in_dst;
            e.mask = in_dst_mask;
            e.data = in_result;
            q.push_back(e);
         end
      end
   endtask

   // Inputs are set just after a rising edge. Outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
      cmp_model();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int chk_reg;
      bit v;
      int dst;
      bit we;
      logic [NUMLANES-1:0] mask;
      bit exp_hit;
   } hit_vec_t;

   initial begin
      hit_vec_t hv[8];
      logic [DW-1:0] d;

      // Reset state.
      idle(0);
      #12;
      chk("rst_wb_we", DW'(wb_we), DW'(0));
      chk("rst_stall", DW'(stall), DW'(0));
      chk("rst_chk_hit", DW'(chk_hit), DW'(0));
      #6 resetn = 1'b1;
      @(posedge clk); #1;

      // Test 1: a single entry appears in the next cycle and retires on grant.
      drv(1, 3, 1, 16'hFFFF, DW'(32'h7), 1, 0, 0);
      step();
      idle(1); #1;
      chk("t1_we", DW'(wb_we), DW'(1));
      chk("t1_dst", DW'(wb_dst), DW'(3));
      d = wb_data;
      chk("t1_lane0", DW'(d[31:0]), DW'(32'h7));
      step();
      chk("t1_empty", DW'(wb_we), DW'(0));

      // Test 2: fill the queue, hold a fifth request while stalled, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         drv(1, i, 1, 16'hFFFF, rdata(), 0, 0, 0);
         step();
      end
      #1 chk("t2_full", DW'(stall), DW'(1));
      drv(1, 5, 1, 16'hFFFF, rdata(), 0, 0, 0);
      step();
      chk("t2_held", DW'(stall), DW'(1));
      wb_grant = 1'b1; #1;
      chk("t2_head1", DW'(wb_dst), DW'(1));
      step();
      chk("t2_unstall", DW'(stall), DW'(0));
      chk("t2_head2", DW'(wb_dst), DW'(2));
      wb_grant = 1'b0;
      step();
      chk("t2_refull", DW'(stall), DW'(1));
      idle(1);
      for (int k = 2; k <= 5; k++) begin
         #1 chk("t2_drain", DW'(wb_dst), DW'(k));
         step();
      end
      chk("t2_empty", DW'(wb_we), DW'(0));

      // Test 3: a request without write-enable or without active lanes takes no slot.
      drv(1, 7, 0, 16'hFFFF, rdata(), 0, 0, 7);
      step();
      drv(1, 7, 1, 16'h0000, rdata(), 0, 0, 7);
      step();
      chk("t3_we", DW'(wb_we), DW'(0));
      chk("t3_stall", DW'(stall), DW'(0));

      // Test 4: ten cycles of simultaneous enqueue and dequeue at count 1. The pointers wrap.
      drv(1, 0, 1, 16'hFFFF, rdata(), 0, 0, 0);
      step();
      for (int k = 1; k <= 10; k++) begin
         drv(1, k, 1, 16'hFFFF, rdata(), 1, 0, 0);
         #1 chk("t4_order", DW'(wb_dst), DW'(k-1));
         step();
         chk("t4_count1", DW'({wb_we, stall}), DW'(2'b10));
      end
      chk("t4_last", DW'(wb_dst), DW'(10));
      idle(1);
      step();

      // Test 5: pending-write lookup with entries for dst 2 and 6.
      hv[0] = '{6, 0, 0, 0, 16'h0000, 1};
      hv[1] = '{9, 0, 0, 0, 16'h0000, 0};
      hv[2] = '{9, 1, 9, 1, 16'hFFFF, 1};
      hv[3] = '{2, 0, 0, 0, 16'h0000, 1};
      hv[4] = '{9, 1, 9, 0, 16'hFFFF, 0};
      hv[5] = '{9, 1, 9, 1, 16'h0000, 0};
      hv[6] = '{9, 1, 8, 1, 16'hFFFF, 0};
      hv[7] = '{6, 1, 9, 1, 16'h0001, 1};
      drv(1, 2, 1, 16'hFFFF, rdata(), 0, 0, 0); step();
      drv(1, 6, 1, 16'hFFFF, rdata(), 0, 0, 0); step();
      for (int i = 0; i < 8; i++) begin
         drv(hv[i].v, hv[i].dst, hv[i].we, hv[i].mask, rdata(), 0, 0, hv[i].chk_reg);
         #1 chk($sformatf("t5_hit_vec%0d", i), DW'(chk_hit), DW'(hv[i].exp_hit));
         in_valid = 1'b0;
         step();
      end
      idle(1); step(); step();

      // Test 6: flush beats a coincident enqueue and grant. Reset drops wb_we without an edge.
      for (int i = 0; i < 3; i++) begin
         drv(1, 12+i, 1, 16'hFFFF, rdata(), 0, 0, 0);
         step();
      end
      drv(1, 11, 1, 16'hFFFF, rdata(), 1, 1, 0);
      step();
      chk("t6_flush_we", DW'(wb_we), DW'(0));
      chk("t6_flush_stall", DW'(stall), DW'(0));
      for (int i = 0; i < 2; i++) begin
         drv(1, i, 1, 16'hFFFF, rdata(), 0, 0, 0);
         step();
      end
      idle(1);
      #2 resetn = 1'b0;
      #1 chk("t6_async_rst", DW'(wb_we), DW'(0));
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      step();

      // Randomized traffic against the model. Upstream holds in_* while stalled.
      for (int n = 0; n < 400; n++) begin
         if (!stall) begin
            drv(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom()),
                rdata(), 0, 0, 0);
         end
         wb_grant = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 31) == 0);
         chk_reg  = REGIDWIDTH'($urandom_range(0, 15));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
